// File: rtl/axi_read_engine_pkg.sv
// Shared constants and FSM state type for the AXI read engine.
// Error checking is compiled in with AXI_RD_ERR_CHECK_EN.
package axi_read_engine_pkg;

    localparam int AXI_DATA_W = 512;
    localparam int AXI_ADDR_W = 64;

    localparam logic [2:0] ARSIZE_64B = 3'd6;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        HOLD
    } state_t;

endpackage

// File: rtl/burst_len_fifo.sv
// Synchronous FIFO holding the arlen of every burst still awaiting rlast.
// Full/empty flags; push ignored when full, pop ignored when empty.
module burst_len_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_read_engine.sv
// AXI4 read-burst issuer with pass-through R stream and outstanding tracking.
// Define AXI_RD_ERR_CHECK_EN to build the protocol/alignment error checker.
module axi_read_engine
    import axi_read_engine_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WIDTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [7:0]            rd_len,
    input  logic [AXI_ADDR_W-1:0] rd_address,
    output logic                  rd_req_ack,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    output logic [AXI_DATA_W-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic                  rd_axi_last,
    output logic                  busy,
    output logic                  err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    state_t          state;
    state_t          state_next;
    logic [OW-1:0]   outstanding;
    logic [7:0]      beat_cnt;
    logic [7:0]      head_len;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            ar_hs;
    logic            r_hs;
    logic            rlast_hs;
    logic            dec;

    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && rd_data_ready;
    assign rlast_hs = r_hs && m_axi_rlast;
    assign dec      = rlast_hs && (outstanding != '0);
    assign accept   = (state == IDLE) && rd_req &&
                      (outstanding < MAX_CNT) && !fifo_full;

    assign m_axi_arsize  = ARSIZE_64B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arid    = '0;

    assign m_axi_rready  = rd_data_ready;
    assign rd_data       = m_axi_rdata;
    assign rd_data_valid = m_axi_rvalid;
    assign rd_axi_last   = rlast_hs;

    assign busy = (state != IDLE) || (outstanding != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack is combinational with the AR handshake so the requester's
    // drop of rd_req lands in HOLD, where it is ignored.
    always_comb begin
        state_next    = state;
        m_axi_arvalid = 1'b0;
        rd_req_ack    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    rd_req_ack = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
        end else if (accept) begin
            m_axi_araddr <= rd_address;
            m_axi_arlen  <= rd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            unique case ({ar_hs, dec})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Beats arriving with no tracked burst (e.g. after reset) are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (r_hs && !fifo_empty) begin
            beat_cnt <= m_axi_rlast ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    burst_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (8)
    ) u_len_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data (m_axi_arlen),
        .pop       (rlast_hs),
        .pop_data  (head_len),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef AXI_RD_ERR_CHECK_EN
    logic        err_q;
    logic        err_set;
    logic        tracked;
    logic [14:0] span_end;

    assign tracked  = r_hs && !fifo_empty;
    assign span_end = {3'b0, rd_address[11:0]} +
                      {({1'b0, rd_len} + 9'd1), 6'b0};

    always_comb begin
        err_set = 1'b0;
        if (r_hs && (m_axi_rresp != RESP_OKAY)) begin
            err_set = 1'b1;
        end
        if (tracked && m_axi_rlast && (beat_cnt != head_len)) begin
            err_set = 1'b1;
        end
        if (tracked && !m_axi_rlast && (beat_cnt == head_len)) begin
            err_set = 1'b1;
        end
        if (accept && (rd_address[5:0] != 6'd0)) begin
            err_set = 1'b1;
        end
        if (accept && (span_end > 15'd4096)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{m_axi_rresp, head_len};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_engine.sv
// Directed self-checking bench for axi_read_engine.
// Error-flag scenarios run when AXI_RD_ERR_CHECK_EN is defined.
module tb_axi_read_engine;

    logic         clk;
    logic         rst_n;
    logic         rd_req;
    logic [7:0]   rd_len;
    logic [63:0]  rd_address;
    logic         rd_req_ack;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic [3:0]   m_axi_arid;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic [511:0] rd_data;
    logic         rd_data_valid;
    logic         rd_data_ready;
    logic         rd_axi_last;
    logic         busy;
    logic         err;

    int checks;
    int failures;

    axi_read_engine #(
        .MAX_OUTSTANDING (8),
        .ID_WIDTH        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req        (rd_req),
        .rd_len        (rd_len),
        .rd_address    (rd_address),
        .rd_req_ack    (rd_req_ack),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arid    (m_axi_arid),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_axi_last   (rd_axi_last),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rd_req        = 1'b0;
        rd_len        = '0;
        rd_address    = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        rd_data_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [63:0] a,
                         input logic [7:0] l,
                         output bit ok);
        rd_req        = 1'b1;
        rd_address    = a;
        rd_len        = l;
        m_axi_arready = 1'b1;
        ok            = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (rd_req_ack) ok = 1'b1;
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic beat(input logic last, input logic [1:0] resp);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = last;
        m_axi_rresp  = resp;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    initial begin
        bit           ok;
        int           acks;
        int           bad;
        int           lasts;
        int           last_idx;
        logic [511:0] exp_data;

        checks   = 0;
        failures = 0;

        do_reset();
        #1;
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_ack", rd_req_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b1;
        rd_data_ready = 1'b0;
        #1;
        chk("noready_last", rd_axi_last, 0);
        chk("rready_pass", m_axi_rready, 0);
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        rd_data_ready = 1'b1;

        // Single 64-beat burst at 0x1000
        rd_req        = 1'b1;
        rd_address    = 64'h1000;
        rd_len        = 8'd63;
        m_axi_arready = 1'b1;
        tick();
        chk("b1_arvalid", m_axi_arvalid, 1);
        chk("b1_araddr", m_axi_araddr, 64'h1000);
        chk("b1_arlen", m_axi_arlen, 63);
        chk("b1_ack", rd_req_ack, 1);
        chk("b1_arsize", m_axi_arsize, 6);
        chk("b1_arburst", m_axi_arburst, 1);
        chk("b1_arid", m_axi_arid, 0);
        rd_req = 1'b0;
        tick();
        chk("b1_hold_ack", rd_req_ack, 0);
        chk("b1_hold_arvalid", m_axi_arvalid, 0);
        tick();
        chk("b1_busy_wait", busy, 1);
        bad      = 0;
        lasts    = 0;
        last_idx = -1;
        for (int i = 0; i < 64; i++) begin
            exp_data     = {16{32'(i) ^ 32'hA5A5_0000}};
            m_axi_rdata  = exp_data;
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (i == 63);
            #1;
            if (rd_data !== exp_data || rd_data_valid !== 1'b1) bad++;
            if (rd_axi_last === 1'b1) begin
                lasts++;
                last_idx = i;
            end
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("b1_data_bad", bad, 0);
        chk("b1_last_count", lasts, 1);
        chk("b1_last_idx", last_idx, 63);
        chk("b1_busy_done", busy, 0);
        chk("b1_err", err, 0);

        // AR stall: arready low for 10 cycles
        rd_req        = 1'b1;
        rd_address    = 64'h2000;
        rd_len        = 8'd3;
        m_axi_arready = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            rd_address = 64'hDEAD_0000;
            rd_len     = 8'd9;
            #1;
            if (m_axi_arvalid !== 1'b1) bad++;
            if (m_axi_araddr !== 64'h2000) bad++;
            if (m_axi_arlen !== 8'd3) bad++;
            if (rd_req_ack !== 1'b0) bad++;
            tick();
        end
        chk("stall_stable_bad", bad, 0);
        m_axi_arready = 1'b1;
        #1;
        chk("stall_ack", rd_req_ack, 1);
        rd_req = 1'b0;
        tick();
        m_axi_arready = 1'b0;
        #1;
        chk("stall_ack_drop", rd_req_ack, 0);
        tick();
        beat(1'b0, 2'b00);
        beat(1'b0, 2'b00);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        #1;
        chk("stall_busy_done", busy, 0);
        chk("stall_err", err, 0);

        // Outstanding limit: nine requests, no R traffic
        do_reset();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            issue(64'(i) << 6, 8'd0, ok);
            if (ok) acks++;
        end
        chk("lim_acks", acks, 8);
        chk("lim_outst", dut.outstanding, 8);
        chk("lim_busy", busy, 1);
        rd_req        = 1'b1;
        rd_address    = 64'h200;
        rd_len        = 8'd0;
        m_axi_arready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_axi_arvalid !== 1'b0) bad++;
            if (rd_req_ack !== 1'b0) bad++;
        end
        chk("lim_ninth_held", bad, 0);
        beat(1'b1, 2'b00);
        chk("lim_outst_dec", dut.outstanding, 7);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (rd_req_ack) ok = 1'b1;
            else tick();
        end
        chk("lim_ninth_ack", ok, 1);
        chk("lim_ninth_addr", m_axi_araddr, 64'h200);
        rd_req = 1'b0;
        tick();
        tick();
        chk("lim_outst_full", dut.outstanding, 8);

        // AR and rlast handshakes in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) issue(64'(i) << 6, 8'd0, ok);
        chk("sim_outst_pre", dut.outstanding, 3);
        rd_req        = 1'b1;
        rd_address    = 64'h400;
        rd_len        = 8'd0;
        m_axi_arready = 1'b0;
        tick();
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b1;
        #1;
        chk("sim_ack", rd_req_ack, 1);
        chk("sim_last", rd_axi_last, 1);
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        rd_req       = 1'b0;
        chk("sim_outst", dut.outstanding, 3);
        chk("sim_err", err, 0);

        // Reset during beat 20 of 64
        do_reset();
        issue(64'h1000, 8'd63, ok);
        chk("mid_issue", ok, 1);
        for (int i = 0; i < 19; i++) beat(1'b0, 2'b00);
        m_axi_rvalid = 1'b1;
        rst_n        = 1'b0;
        tick();
        rst_n        = 1'b1;
        m_axi_rvalid = 1'b0;
        m_axi_arready = 1'b0;
        #1;
        chk("mid_arvalid", m_axi_arvalid, 0);
        chk("mid_ack", rd_req_ack, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_araddr", m_axi_araddr, 0);
        chk("mid_arlen", m_axi_arlen, 0);
        chk("mid_outst", dut.outstanding, 0);
        chk("mid_beat", dut.beat_cnt, 0);
        lasts = 0;
        for (int i = 20; i < 64; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (i == 63);
            #1;
            if (rd_axi_last === 1'b1) lasts++;
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        chk("mid_tail_last", lasts, 1);
        chk("mid_tail_outst", dut.outstanding, 0);
        chk("mid_tail_beat", dut.beat_cnt, 0);
        chk("mid_tail_busy", busy, 0);
        issue(64'h3000, 8'd1, ok);
        chk("post_issue", ok, 1);
        chk("post_araddr", m_axi_araddr, 64'h3000);
        chk("post_busy", busy, 1);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        chk("post_busy_done", busy, 0);
        chk("post_err", err, 0);

`ifdef AXI_RD_ERR_CHECK_EN
        do_reset();
        issue(64'h4000, 8'd7, ok);
        for (int i = 0; i < 5; i++) beat(1'b0, 2'b00);
        chk("e_resp_pre", err, 0);
        beat(1'b0, 2'b10);
        chk("e_resp_set", err, 1);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        chk("e_resp_sticky", err, 1);
        do_reset();
        #1;
        chk("e_rst_clear", err, 0);
        issue(64'h4000, 8'd3, ok);
        beat(1'b0, 2'b00);
        chk("e_early_pre", err, 0);
        beat(1'b1, 2'b00);
        chk("e_early_last", err, 1);
        do_reset();
        issue(64'h0FC0, 8'd1, ok);
        chk("e_4k_cross", err, 1);
        do_reset();
        issue(64'h1010, 8'd0, ok);
        chk("e_unaligned", err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
